// File: rtl/acumulador_credito.sv
// Credit accumulator: collects coins, runs the vend handshake, pays change/refund as unit pulses.
// Optional idle auto-refund enabled by defining ACUM_TIMEOUT_EN.
module acumulador_credito #(
    parameter int PRECIO      = 20,
    parameter int MAX_CREDITO = 31,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       cancel,
    input  logic       vend_ack,
    output logic [4:0] credito,
    output logic       hay_credito,
    output logic       vend_req,
    output logic       coin_reject,
    output logic       change_pulse,
    output logic       busy
);
    typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

    state_t     state;
    logic [5:0] coin_units;
    logic [5:0] sum;
    logic       coin_fits;
    logic [4:0] remainder;
    logic       tmo_hit;
    logic       refund_req;

    if (PRECIO < 1 || PRECIO > MAX_CREDITO || MAX_CREDITO > 31 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("acumulador_credito: illegal parameter combination");
    end

    always_comb begin
        coin_units = 6'd1;
        case (coin_value)
            2'b00: coin_units = 6'd1;
            2'b01: coin_units = 6'd2;
            2'b10: coin_units = 6'd5;
            2'b11: coin_units = 6'd10;
            default: coin_units = 6'd1;
        endcase
    end

    // One extra bit on the sum so an oversized coin is refused instead of wrapping
    assign sum        = {1'b0, credito} + coin_units;
    assign coin_fits  = (sum <= 6'(MAX_CREDITO));
    assign remainder  = credito - 5'(PRECIO);
    assign refund_req = (cancel || tmo_hit) && (credito != 5'd0);

`ifdef ACUM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt;
    logic          coin_ok;

    assign tmo_hit = (state == COLLECT) && (credito != 5'd0) && !hay_credito &&
                     (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign coin_ok = (state == COLLECT) && coin_valid && coin_fits && !cancel && !hay_credito;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state != COLLECT || credito == 5'd0 || hay_credito || coin_ok || tmo_hit)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= COLLECT;
            credito      <= 5'd0;
            hay_credito  <= 1'b0;
            vend_req     <= 1'b0;
            coin_reject  <= 1'b0;
            change_pulse <= 1'b0;
            busy         <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            case (state)
                COLLECT: begin
                    if (refund_req) begin
                        state       <= CHANGE;
                        busy        <= 1'b1;
                        hay_credito <= 1'b0;
                        coin_reject <= coin_valid;
                    end else if (hay_credito) begin
                        state       <= VEND;
                        vend_req    <= 1'b1;
                        busy        <= 1'b1;
                        coin_reject <= coin_valid;
                    end else if (coin_valid) begin
                        if (coin_fits) begin
                            credito     <= sum[4:0];
                            hay_credito <= (sum >= 6'(PRECIO));
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    coin_reject <= coin_valid;
                    if (vend_ack) begin
                        credito     <= remainder;
                        vend_req    <= 1'b0;
                        hay_credito <= 1'b0;
                        if (remainder != 5'd0) begin
                            state <= CHANGE;
                        end else begin
                            state <= COLLECT;
                            busy  <= 1'b0;
                        end
                    end
                end
                CHANGE: begin
                    coin_reject <= coin_valid;
                    // Entry cycle counts as a low cycle; leave after the low cycle following the last pulse
                    if (change_pulse) begin
                        change_pulse <= 1'b0;
                    end else if (credito != 5'd0) begin
                        change_pulse <= 1'b1;
                        credito      <= credito - 5'd1;
                    end else begin
                        state <= COLLECT;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= COLLECT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_acumulador_credito.sv
// Directed self-checking bench for acumulador_credito (PRECIO=20, plus a PRECIO=30 copy for saturation).
module tb_acumulador_credito;
    logic       clk, rst, coin_valid, cancel, vend_ack;
    logic [1:0] coin_value;
    logic [4:0] credito, s_credito;
    logic       hay_credito, vend_req, coin_reject, change_pulse, busy;
    logic       s_hay, s_vend_req, s_coin_reject, s_change_pulse, s_busy;
    int errors = 0;
    int checks = 0;

    acumulador_credito #(.PRECIO(20), .MAX_CREDITO(31), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
        .cancel(cancel), .vend_ack(vend_ack), .credito(credito), .hay_credito(hay_credito),
        .vend_req(vend_req), .coin_reject(coin_reject), .change_pulse(change_pulse), .busy(busy));

    acumulador_credito #(.PRECIO(30), .MAX_CREDITO(31), .TIMEOUT_CYC(1000)) dut_sat (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
        .cancel(cancel), .vend_ack(vend_ack), .credito(s_credito), .hay_credito(s_hay),
        .vend_req(s_vend_req), .coin_reject(s_coin_reject), .change_pulse(s_change_pulse), .busy(s_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; coin_valid = 1'b0; coin_value = 2'b00; cancel = 1'b0; vend_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Runs until busy drops (bounded), measuring pulses, gaps, vend_req and credit tracking
    task automatic drain(input int start, output int npulse, output int bad_gap,
                         output int vreq, output int bad_cred);
        int last;
        last = -10; npulse = 0; bad_gap = 0; vreq = 0; bad_cred = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            tick();
            if (change_pulse) begin
                if (npulse > 0 && i - last != 2) bad_gap++;
                last = i;
                npulse++;
                if (int'(credito) != start - npulse) bad_cred++;
            end
            if (vend_req) vreq++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; coin_valid = 1'b0; coin_value = 2'b00; cancel = 1'b0; vend_ack = 1'b0;
        #1;
        checks++;
        if ({credito, hay_credito, vend_req, coin_reject, change_pulse, busy} !== 10'd0) begin
            errors++; $display("FAIL reset_outputs: got %b want 0", {credito, hay_credito, vend_req, coin_reject, change_pulse, busy});
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({credito, busy, vend_req} !== 7'd0) begin
            errors++; $display("FAIL reset_release: got %b want 0", {credito, busy, vend_req});
        end
    endtask

    task automatic test_exact_payment();
        int bad;
        do_reset();
        coin(2'b11);
        coin(2'b11);
        checks++;
        if (credito !== 5'd20 || hay_credito !== 1'b1) begin
            errors++; $display("FAIL exact_credit: got credito=%0d hay=%b want 20/1", credito, hay_credito);
        end
        tick();
        checks++;
        if (vend_req !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL exact_vend_req: got req=%b busy=%b want 1/1", vend_req, busy);
        end
        tick(); tick();
        checks++;
        if (vend_req !== 1'b1) begin
            errors++; $display("FAIL exact_req_hold: got %b want 1", vend_req);
        end
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        checks++;
        if (credito !== 5'd0 || vend_req !== 1'b0 || hay_credito !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL exact_after_ack: got cred=%0d req=%b hay=%b busy=%b want 0/0/0/0",
                               credito, vend_req, hay_credito, busy);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (change_pulse || busy) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL exact_no_change: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_overpayment();
        int n, gap, vr, bc;
        // Ordering A: 10,5,10 all land in COLLECT
        do_reset();
        coin(2'b11); coin(2'b10); coin(2'b11);
        checks++;
        if (credito !== 5'd25 || hay_credito !== 1'b1) begin
            errors++; $display("FAIL over_credit: got credito=%0d hay=%b want 25/1", credito, hay_credito);
        end
        tick();
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        checks++;
        if (credito !== 5'd5 || busy !== 1'b1 || vend_req !== 1'b0) begin
            errors++; $display("FAIL over_after_ack: got cred=%0d busy=%b req=%b want 5/1/0", credito, busy, vend_req);
        end
        drain(5, n, gap, vr, bc);
        checks++;
        if (n !== 5 || gap !== 0 || bc !== 0) begin
            errors++; $display("FAIL over_change: got pulses=%0d badgap=%0d badcred=%0d want 5/0/0", n, gap, bc);
        end
        checks++;
        if (busy !== 1'b0 || credito !== 5'd0) begin
            errors++; $display("FAIL over_done: got busy=%b cred=%0d want 0/0", busy, credito);
        end
        // Ordering B: 10,10,5 back to back -- the 5 meets the vend transition and is refused
        do_reset();
        coin(2'b11); coin(2'b11); coin(2'b10);
        checks++;
        if (coin_reject !== 1'b1 || vend_req !== 1'b1 || credito !== 5'd20) begin
            errors++; $display("FAIL over_prio_reject: got rej=%b req=%b cred=%0d want 1/1/20", coin_reject, vend_req, credito);
        end
        tick();
        checks++;
        if (coin_reject !== 1'b0) begin
            errors++; $display("FAIL over_reject_width: got %b want 0", coin_reject);
        end
        coin(2'b00);
        checks++;
        if (coin_reject !== 1'b1 || credito !== 5'd20) begin
            errors++; $display("FAIL vend_coin_reject: got rej=%b cred=%0d want 1/20", coin_reject, credito);
        end
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        checks++;
        if (credito !== 5'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL over_b_done: got cred=%0d busy=%b want 0/0", credito, busy);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        coin(2'b11); coin(2'b11); coin(2'b10); coin(2'b01); coin(2'b01);
        checks++;
        if (s_credito !== 5'd29 || s_hay !== 1'b0) begin
            errors++; $display("FAIL sat_credit: got %0d hay=%b want 29/0", s_credito, s_hay);
        end
        coin(2'b10);
        checks++;
        if (s_coin_reject !== 1'b1 || s_credito !== 5'd29) begin
            errors++; $display("FAIL sat_reject: got rej=%b cred=%0d want 1/29", s_coin_reject, s_credito);
        end
        tick();
        checks++;
        if (s_coin_reject !== 1'b0) begin
            errors++; $display("FAIL sat_reject_width: got %b want 0", s_coin_reject);
        end
        coin(2'b01);
        checks++;
        if (s_credito !== 5'd31 || s_hay !== 1'b1) begin
            errors++; $display("FAIL sat_ceiling: got %0d hay=%b want 31/1", s_credito, s_hay);
        end
    endtask

    task automatic test_cancel();
        int n, gap, vr, bc, bad;
        do_reset();
        coin(2'b10); coin(2'b01);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b1 || credito !== 5'd7 || change_pulse !== 1'b0) begin
            errors++; $display("FAIL cancel_entry: got busy=%b cred=%0d pulse=%b want 1/7/0", busy, credito, change_pulse);
        end
        drain(7, n, gap, vr, bc);
        checks++;
        if (n !== 7 || gap !== 0 || vr !== 0 || bc !== 0) begin
            errors++; $display("FAIL cancel_refund: got pulses=%0d badgap=%0d vreq=%0d badcred=%0d want 7/0/0/0", n, gap, vr, bc);
        end
        checks++;
        if (busy !== 1'b0 || credito !== 5'd0) begin
            errors++; $display("FAIL cancel_done: got busy=%b cred=%0d want 0/0", busy, credito);
        end
        cancel = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy || change_pulse || credito != 5'd0) bad++;
        end
        cancel = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL cancel_empty: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_async_reset();
        int bad;
        do_reset();
        coin(2'b10);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (credito !== 5'd3 || change_pulse !== 1'b1) begin
            errors++; $display("FAIL arst_setup: got cred=%0d pulse=%b want 3/1", credito, change_pulse);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({credito, hay_credito, vend_req, coin_reject, change_pulse, busy} !== 10'd0) begin
            errors++; $display("FAIL arst_immediate: got %b want 0", {credito, hay_credito, vend_req, coin_reject, change_pulse, busy});
        end
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (change_pulse || busy || credito != 5'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL arst_quiet: got %0d active cycles want 0", bad);
        end
    endtask

`ifdef ACUM_TIMEOUT_EN
    task automatic test_timeout();
        int n, gap, vr, bc;
        do_reset();
        coin(2'b01);
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL tmo_early: got busy=%b want 0", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL tmo_fire: got busy=%b want 1", busy);
        end
        drain(2, n, gap, vr, bc);
        checks++;
        if (n !== 2 || gap !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL tmo_refund: got pulses=%0d badgap=%0d busy=%b want 2/0/0", n, gap, busy);
        end
        do_reset();
        coin(2'b01);
        for (int i = 0; i < 9; i++) tick();
        coin(2'b00);
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (busy !== 1'b0 || credito !== 5'd3) begin
            errors++; $display("FAIL tmo_restart_early: got busy=%b cred=%0d want 0/3", busy, credito);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL tmo_restart_fire: got busy=%b want 1", busy);
        end
        drain(3, n, gap, vr, bc);
        checks++;
        if (n !== 3 || busy !== 1'b0) begin
            errors++; $display("FAIL tmo_restart_refund: got pulses=%0d busy=%b want 3/0", n, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_exact_payment();
        test_overpayment();
        test_saturation();
        test_cancel();
        test_async_reset();
`ifdef ACUM_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
